serial_subtractor_16bit: RTL

Bit-serial 16-bit two's-complement subtractor computing `a - b` one bit per clock, LSB first, using a single full-adder slice with `a + ~b + 1`. It is the subtract-direction counterpart to the combinational 16-bit ripple adder. It sits in the datapath where area matters more than latency, and uses a start/done handshake so that a controller can issue operations back-to-back.

---
 rtl/serial_subtractor_16bit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor_16bit.sv
// serial_subtractor_16bit
//
// Bit-serial two's-complement subtractor. It computes a - b one bit per clock,
// LSB first, with a single full-adder slice evaluating a + ~b + 1. The carry
// flop is seeded with 1 when an operation is accepted. A start/done handshake
// lets a controller issue operations back-to-back: a start presented in the
// DONE cycle is accepted immediately.
//
// Ports:
//   clk      - sole clock, rising edge
//   rst      - synchronous active-high reset
//   start    - request a subtraction (sampled only when busy = 0)
//   a, b     - minuend / subtrahend, captured on the accepted start edge
//   busy     - high while the bit-serial calculation runs
//   done     - one-cycle pulse; the result is valid from this cycle onward
//   diff     - a - b modulo 2^WIDTH, held until the next completed operation
//              or reset
//   borrow   - unsigned borrow (a < b)
//   overflow - signed overflow of the subtraction

module serial_subtractor_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] ra, rb, acc;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic accept, last_bit, nb, sum_bit, carry_next;

  // Full-adder slice and control decode. An operation can be accepted from
  // IDLE or from DONE, which is what makes back-to-back issue possible.
  always_comb begin
    accept     = 1'b0;
    nb         = ~rb[0];
    sum_bit    = ra[0] ^ nb ^ carry;
    carry_next = (ra[0] & nb) | (ra[0] & carry) | (nb & carry);
    last_bit   = (cnt == CW'(WIDTH - 1));
    if ((state == IDLE || state == DONE) && start) begin
      accept = 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (last_bit) state_next = DONE;
      DONE:    state_next = accept ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The state register. busy and done are registered from the next state,
  // so they come straight off flops with no path from the inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == CALC);
      done  <= (state_next == DONE);
    end
  end

  // Datapath. acc collects the partial result privately. diff is loaded only
  // on the final bit, so partial values never show on the output. On that
  // final bit ra[0] and rb[0] hold the original operand MSBs, because the
  // operands have been shifted WIDTH-1 times. The overflow term can therefore
  // use them directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra       <= '0;
      rb       <= '0;
      acc      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      ra    <= a;
      rb    <= b;
      carry <= 1'b1;
      cnt   <= '0;
    end else if (state == CALC) begin
      acc   <= {sum_bit, acc[WIDTH-1:1]};
      ra    <= ra >> 1;
      rb    <= rb >> 1;
      carry <= carry_next;
      cnt   <= cnt + 1'b1;
      if (last_bit) begin
        diff     <= {sum_bit, acc[WIDTH-1:1]};
        borrow   <= ~carry_next;
        overflow <= (ra[0] != rb[0]) && (sum_bit != ra[0]);
      end
    end
  end

  // Simulation-only: an accepted start must have fully known operands.
  a_known_inputs : assert property (
    @(posedge clk) disable iff (rst)
      (state != CALC) |-> (!$isunknown(start) && (!start || !$isunknown({a, b})))
  ) else $error("serial_subtractor_16bit: X/Z on start/a/b at accepted edge");

endmodule
